paddle_input_ctrl: RTL and testbench

- Front end driving a paddle module: turns raw board push-buttons into paddle movement commands (indoCima, mover) and a one-cycle hit pulse (porradao).
- Sits between the board KEY pins and the paddle position logic. Synchronises, debounces and rate-limits the buttons. Enforces a cooldown on the hit action.
- One instance per player.

---
 rtl/paddle_input_ctrl.sv | 159 +++++++++++++++
 tb/tb_paddle_input_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/paddle_input_ctrl.sv
// Button front end for one paddle: synchronise, debounce, rate-limit movement,
// and gate the hit action behind a cooldown.
module paddle_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MOVE_DIV        = 250000,
   parameter int COOLDOWN_CYCLES = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up_n,
   input  logic btn_down_n,
   input  logic btn_hit_n,
   output logic indoCima,
   output logic mover,
   output logic porradao,
   output logic hit_ready
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [MW-1:0] MMAX = MW'(MOVE_DIV - 1);
   localparam logic [CW-1:0] CMAX = CW'(COOLDOWN_CYCLES - 1);

   typedef enum logic [1:0] {
      READY,
      FIRE,
      COOLDOWN,
      WAIT_RELEASE
   } hit_state_t;

   // bit 0 = up, bit 1 = down, bit 2 = hit
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    btn_s;
   logic [2:0]    st;
   logic [2:0]    st_nx;
   logic [DW-1:0] db_cnt [3];
   logic [DW-1:0] db_cnt_nx [3];

   logic          act;
   logic          act_nx;
   logic [MW-1:0] mv_cnt;

   hit_state_t    state;
   hit_state_t    state_nx;
   logic [CW-1:0] cd_cnt;
   logic [CW-1:0] cd_cnt_nx;

   assign btn_s = ~sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 3'b111;
         sync2 <= 3'b111;
      end else begin
         sync1 <= {btn_hit_n, btn_down_n, btn_up_n};
         sync2 <= sync1;
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         st_nx[i]     = st[i];
         db_cnt_nx[i] = '0;
         if (btn_s[i] != st[i]) begin
            if (db_cnt[i] == DMAX) begin
               st_nx[i] = btn_s[i];
            end else begin
               db_cnt_nx[i] = db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         st <= st_nx;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= db_cnt_nx[i];
         end
      end
   end

   // Outputs are driven from the next debounced state so they line up
   // with the cycle in which the debounced level changes.
   assign act    = st[0] ^ st[1];
   assign act_nx = st_nx[0] ^ st_nx[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         indoCima <= 1'b0;
         mover    <= 1'b0;
         mv_cnt   <= '0;
      end else begin
         if (st_nx[0] && !st_nx[1]) begin
            indoCima <= 1'b1;
         end else if (!st_nx[0] && st_nx[1]) begin
            indoCima <= 1'b0;
         end
         if (!act_nx) begin
            mover  <= 1'b0;
            mv_cnt <= '0;
         end else if (!act || mv_cnt == MMAX) begin
            mover  <= 1'b1;
            mv_cnt <= '0;
         end else begin
            mover  <= 1'b0;
            mv_cnt <= mv_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= READY;
         cd_cnt <= '0;
      end else begin
         state  <= state_nx;
         cd_cnt <= cd_cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cd_cnt_nx = cd_cnt;
      unique case (state)
         READY: begin
            if (st_nx[2]) state_nx = FIRE;
         end
         FIRE: begin
            cd_cnt_nx = '0;
            state_nx  = COOLDOWN;
         end
         COOLDOWN: begin
            if (cd_cnt == CMAX) begin
               state_nx = WAIT_RELEASE;
            end else begin
               cd_cnt_nx = cd_cnt + 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (!st_nx[2]) state_nx = READY;
         end
         default: state_nx = READY;
      endcase
   end

   assign porradao  = (state == FIRE);
   assign hit_ready = (state == READY);

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Scoreboard bench for paddle_input_ctrl: expected pulse cycles are queued
// at stimulus time and matched against observed mover/porradao pulses.
module tb_paddle_input_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_up_n = 1'b1;
   logic btn_down_n = 1'b1;
   logic btn_hit_n = 1'b1;
   logic indoCima;
   logic mover;
   logic porradao;
   logic hit_ready;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int mv_q[$];
   int po_q[$];

   paddle_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .MOVE_DIV(8),
      .COOLDOWN_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_up_n(btn_up_n),
      .btn_down_n(btn_down_n),
      .btn_hit_n(btn_hit_n),
      .indoCima(indoCima),
      .mover(mover),
      .porradao(porradao),
      .hit_ready(hit_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse monitor: match pulses to queued cycles, flag missed ones.
   always @(negedge clk) begin
      while (mv_q.size() > 0 && mv_q[0] < cyc) begin
         chk("mover_missed", cyc, mv_q[0]);
         void'(mv_q.pop_front());
      end
      while (po_q.size() > 0 && po_q[0] < cyc) begin
         chk("hit_missed", cyc, po_q[0]);
         void'(po_q.pop_front());
      end
      if (mover === 1'b1) begin
         if (mv_q.size() > 0) chk("mover_time", cyc, mv_q.pop_front());
         else chk("mover_unexpected", cyc, 0);
      end
      if (porradao === 1'b1) begin
         if (po_q.size() > 0) chk("hit_time", cyc, po_q.pop_front());
         else chk("hit_unexpected", cyc, 0);
      end
   end

   int c0;

   initial begin
      step(3);
      #1;
      chk("rst_outs", {indoCima, mover, porradao, hit_ready}, 4'b0001);
      reset = 1'b0;

      // idle
      for (int i = 0; i < 100; i++) begin
         step(1);
         chk("idle_outs", {indoCima, mover, porradao, hit_ready}, 4'b0001);
      end

      // 3-cycle glitch on up
      btn_up_n = 1'b0;
      step(3);
      btn_up_n = 1'b1;
      step(20);
      chk("glitch_dir", indoCima, 1'b0);

      // up held: strobes at +6, then every 8
      c0 = cyc;
      btn_up_n = 1'b0;
      for (int k = 0; k < 5; k++) mv_q.push_back(c0 + 6 + 8 * k);
      step(5);
      chk("up_dir_pre", indoCima, 1'b0);
      step(1);
      chk("up_dir", indoCima, 1'b1);
      step(34);

      // down added: strobe due at +6 is suppressed, direction holds
      btn_down_n = 1'b0;
      step(20);
      chk("both_dir", indoCima, 1'b1);
      chk("both_q", mv_q.size(), 0);

      // release up: immediate strobe downward
      c0 = cyc;
      btn_up_n = 1'b1;
      mv_q.push_back(c0 + 6);
      mv_q.push_back(c0 + 14);
      step(5);
      chk("down_dir_pre", indoCima, 1'b1);
      step(1);
      chk("down_dir", indoCima, 1'b0);
      step(10);
      btn_down_n = 1'b1;
      step(20);
      chk("down_hold_dir", indoCima, 1'b0);

      // hit held 100 cycles: one pulse
      c0 = cyc;
      btn_hit_n = 1'b0;
      po_q.push_back(c0 + 6);
      step(5);
      chk("hit_rdy_pre", hit_ready, 1'b1);
      step(1);
      chk("hit_rdy_fire", hit_ready, 1'b0);
      step(94);
      btn_hit_n = 1'b1;
      step(5);
      chk("hit_rdy_held", hit_ready, 1'b0);
      step(1);
      chk("hit_rdy_back", hit_ready, 1'b1);
      step(10);

      // short press, re-press during cooldown ignored
      c0 = cyc;
      btn_hit_n = 1'b0;
      po_q.push_back(c0 + 6);
      step(5);
      btn_hit_n = 1'b1;
      step(7);
      btn_hit_n = 1'b0;
      step(6);
      btn_hit_n = 1'b1;
      step(4);
      chk("cd_rdy", hit_ready, 1'b0);
      step(8);
      chk("cd_rdy_back", hit_ready, 1'b1);
      c0 = cyc;
      btn_hit_n = 1'b0;
      po_q.push_back(c0 + 6);
      step(10);
      btn_hit_n = 1'b1;
      step(40);

      // reset during cooldown with up held
      c0 = cyc;
      btn_hit_n = 1'b0;
      btn_up_n = 1'b0;
      po_q.push_back(c0 + 6);
      mv_q.push_back(c0 + 6);
      step(10);
      chk("cd_rdy_mid", hit_ready, 1'b0);
      chk("cd_dir_mid", indoCima, 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_rst_outs", {indoCima, mover, porradao, hit_ready}, 4'b0001);
      step(3);
      btn_hit_n = 1'b1;
      reset = 1'b0;
      c0 = cyc;
      mv_q.push_back(c0 + 6);
      #1;
      chk("post_rst_rdy", hit_ready, 1'b1);
      step(5);
      chk("post_rst_dir_pre", indoCima, 1'b0);
      step(1);
      chk("post_rst_dir", indoCima, 1'b1);
      step(2);
      btn_up_n = 1'b1;
      step(20);

      chk("mv_q_empty", mv_q.size(), 0);
      chk("po_q_empty", po_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
